// File: rtl/mips_pkg.sv
// ----------------------------------------------------------------------------
// mips_pkg
//   Shared definitions for the multicycle MIPS main control FSM:
//   opcodes, ALUOp / ALUSrcB / PCSource codes, the state encoding and the
//   packed control word that the output decoder hands to the top level.
// ----------------------------------------------------------------------------
package mips_pkg;

    // Primary opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    // ALUOp: the ALU control decoder only looks at funct for ALUOP_FUNCT
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU B operand select
    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    // Next-PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Encoding is visible on state_o, so it is fixed explicitly.
    typedef enum logic [3:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_MEMADR = 4'd2,
        ST_MEMRD  = 4'd3,
        ST_MEMWB  = 4'd4,
        ST_MEMWR  = 4'd5,
        ST_EXEC   = 4'd6,
        ST_RWB    = 4'd7,
        ST_BRANCH = 4'd8,
        ST_ADDIEX = 4'd9,
        ST_ADDIWB = 4'd10,
        ST_JUMP   = 4'd11,
        ST_HALT   = 4'd12
    } state_e;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
    } ctrl_t;

endpackage

// File: rtl/mips_ctrl_outdec.sv
// ----------------------------------------------------------------------------
// mips_ctrl_outdec
//   Purely combinational decode of the FSM state into the datapath control
//   word. Moore outputs, except that FETCH gates IRWrite/PCWrite with
//   mem_ready and MEMWR reports completion only when mem_ready is high.
// Ports
//   state_i      current FSM state
//   mem_ready_i  memory completes the current access this cycle
//   ctrl_o       control word for the datapath
// ----------------------------------------------------------------------------
module mips_ctrl_outdec
    import mips_pkg::*;
(
    input  state_e state_i,
    input  logic   mem_ready_i,
    output ctrl_t  ctrl_o
);

    always_comb begin
        // NOTE: every field gets a default before the case so no path through
        // this block leaves a signal unassigned (which would infer a latch).
        ctrl_o = '0;
        unique case (state_i)
            ST_FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.i_or_d    = 1'b0;
                ctrl_o.alu_src_a = 1'b0;
                ctrl_o.alu_src_b = SRCB_FOUR;
                ctrl_o.alu_op    = ALUOP_ADD;
                ctrl_o.pc_source = PCSRC_ALU;
                // IR and PC must not move while the fetch is stalled.
                ctrl_o.ir_write  = mem_ready_i;
                ctrl_o.pc_write  = mem_ready_i;
            end
            ST_DECODE: begin
                // Speculative branch target PC+4+(imm<<2) into ALUOut.
                ctrl_o.alu_src_a = 1'b0;
                ctrl_o.alu_src_b = SRCB_IMM_SH2;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            ST_MEMADR, ST_ADDIEX: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            ST_MEMRD: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.i_or_d   = 1'b1;
            end
            ST_MEMWB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
                ctrl_o.reg_dst    = 1'b0;
                ctrl_o.instr_done = 1'b1;
            end
            ST_MEMWR: begin
                ctrl_o.mem_write  = 1'b1;
                ctrl_o.i_or_d     = 1'b1;
                ctrl_o.instr_done = mem_ready_i;
            end
            ST_EXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_REG;
                ctrl_o.alu_op    = ALUOP_FUNCT;
            end
            ST_RWB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.reg_dst    = 1'b1;
                ctrl_o.mem_to_reg = 1'b0;
                ctrl_o.instr_done = 1'b1;
            end
            ST_BRANCH: begin
                ctrl_o.alu_src_a     = 1'b1;
                ctrl_o.alu_src_b     = SRCB_REG;
                ctrl_o.alu_op        = ALUOP_SUB;
                ctrl_o.pc_write_cond = 1'b1;
                ctrl_o.pc_source     = PCSRC_ALUOUT;
                ctrl_o.instr_done    = 1'b1;
            end
            ST_ADDIWB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.reg_dst    = 1'b0;
                ctrl_o.mem_to_reg = 1'b0;
                ctrl_o.instr_done = 1'b1;
            end
            ST_JUMP: begin
                ctrl_o.pc_write   = 1'b1;
                ctrl_o.pc_source  = PCSRC_JUMP;
                ctrl_o.instr_done = 1'b1;
            end
            // HALT and the unused encodings drive nothing.
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// ----------------------------------------------------------------------------
// mips_multicycle_ctrl
//   Main control FSM of the multicycle MIPS core: sequences PC, memory port,
//   IR, register file and ALU one micro-step per cycle for R-type, lw, sw,
//   beq, j and addi. Memory accesses stall on mem_ready.
// Parameters
//   HALT_ON_ILLEGAL  1: unknown opcode parks in HALT until reset
//                    0: unknown opcode is skipped, back to FETCH
// Ports
//   clk, rst         clock; synchronous active-high reset
//   opcode           IR[31:26], valid from DECODE onward
//   mem_ready        memory completes current read/write this cycle
//   PCWrite .. PCSource  datapath controls (all 0 while rst is high)
//   instr_done       pulse in the last cycle of every completed instruction
//   illegal_op       sticky unknown-opcode flag, cleared only by rst
//   state_o          current state encoding (debug)
// ----------------------------------------------------------------------------
module mips_multicycle_ctrl
    import mips_pkg::*;
#(
    parameter logic HALT_ON_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [3:0] state_o
);

    state_e state_q, state_d;
    logic   illegal_q, illegal_d;
    ctrl_t  ctrl_raw, ctrl;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of order.
        if (rst) begin
            state_q   <= ST_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        unique case (state_q)
            ST_FETCH:  if (mem_ready) state_d = ST_DECODE;
            ST_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = ST_MEMADR;
                    OP_RTYPE:     state_d = ST_EXEC;
                    OP_BEQ:       state_d = ST_BRANCH;
                    OP_ADDI:      state_d = ST_ADDIEX;
                    OP_J:         state_d = ST_JUMP;
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = HALT_ON_ILLEGAL ? ST_HALT : ST_FETCH;
                    end
                endcase
            end
            ST_MEMADR: begin
                // Only lw/sw reach here; anything else is abandoned safely.
                if (opcode == OP_LW)      state_d = ST_MEMRD;
                else if (opcode == OP_SW) state_d = ST_MEMWR;
                else                      state_d = ST_FETCH;
            end
            ST_MEMRD:  if (mem_ready) state_d = ST_MEMWB;
            ST_MEMWR:  if (mem_ready) state_d = ST_FETCH;
            ST_EXEC:   state_d = ST_RWB;
            ST_ADDIEX: state_d = ST_ADDIWB;
            ST_MEMWB, ST_RWB, ST_BRANCH, ST_ADDIWB, ST_JUMP:
                       state_d = ST_FETCH;
            ST_HALT:   state_d = ST_HALT;
            // Unused encodings recover through FETCH.
            default:   state_d = ST_FETCH;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode; reset forces every control off immediately, so an
    // access in flight is dropped in the same cycle rst is seen.
    // ------------------------------------------------------------------
    mips_ctrl_outdec u_outdec (
        .state_i     (state_q),
        .mem_ready_i (mem_ready),
        .ctrl_o      (ctrl_raw)
    );

    assign ctrl = rst ? '0 : ctrl_raw;

    assign PCWrite     = ctrl.pc_write;
    assign PCWriteCond = ctrl.pc_write_cond;
    assign IorD        = ctrl.i_or_d;
    assign MemRead     = ctrl.mem_read;
    assign MemWrite    = ctrl.mem_write;
    assign IRWrite     = ctrl.ir_write;
    assign MemtoReg    = ctrl.mem_to_reg;
    assign RegDst      = ctrl.reg_dst;
    assign RegWrite    = ctrl.reg_write;
    assign ALUSrcA     = ctrl.alu_src_a;
    assign ALUSrcB     = ctrl.alu_src_b;
    assign ALUOp       = ctrl.alu_op;
    assign PCSource    = ctrl.pc_source;
    assign instr_done  = ctrl.instr_done;

    assign illegal_op = illegal_q;
    assign state_o    = state_q;

endmodule
